// File: rtl/xbar_out_alloc.sv
// Per-output-port crossbar allocator: qualifies requests by destination, grants one with
// rotating priority, and holds the grant by request-hold (optional cap) or packet lock.
module xbar_out_alloc #(
    parameter int NPORT    = 5,
    parameter int PORTW    = 3,
    parameter int PORTID   = 0,
    parameter int LOCKMODE = 0,
    parameter int MAXHOLD  = 0,
    localparam int IW      = $clog2(NPORT),
    localparam int HW      = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NPORT*PORTW-1:0] dest,
    input  logic [NPORT-1:0]       req,
    input  logic [NPORT-1:0]       tail,
    input  logic                   out_ready,
    output logic [NPORT-1:0]       grt,
    output logic [NPORT-1:0]       sel,
    output logic [IW-1:0]          owner,
    output logic                   busy,
    output logic                   dbg_state,
    output logic [IW-1:0]          dbg_ptr,
    output logic [HW-1:0]          dbg_hold_cnt
);

    // Handshake: a flit on port i transfers in the cycle grt[i]=1. grt is only raised when
    // req[i] (valid), the destination match and out_ready (ready) all hold, so grt is the
    // combined valid&ready; there is no separate acknowledge.

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    ptr, ptr_n;
    logic [IW-1:0]    owner_r, owner_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic [NPORT-1:0] sel_r;

    logic [NPORT-1:0] q;
    logic [NPORT-1:0] cand;
    logic [IW-1:0]    base;
    logic [IW-1:0]    idx;
    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic             keep_owner;

    always_comb begin
        q = '0;
        for (int i = 0; i < NPORT; i++) begin
            q[i] = req[i] && (dest[i*PORTW +: PORTW] == PORTW'(PORTID));
        end
    end

    // While locked the owner is excluded, so the search yields "any other requester".
    always_comb begin
        cand     = q;
        base     = ptr;
        idx      = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        if (state == LOCKED) begin
            cand[owner_r] = 1'b0;
            base          = owner_r;
        end
        // Descending scan so the nearest port after base is the last one assigned.
        for (int k = NPORT; k >= 1; k--) begin
            idx = IW'((int'(base) + k) % NPORT);
            if (cand[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_comb begin
        win_vld    = 1'b0;
        win_idx    = pick_idx;
        keep_owner = 1'b0;
        if (out_ready && rst_) begin
            if (state == IDLE) begin
                win_vld = pick_vld;
            end else if (LOCKMODE == 0) begin
                if (q[owner_r] && ((MAXHOLD == 0) || (int'(hold_cnt) < MAXHOLD) || !pick_vld)) begin
                    win_vld    = 1'b1;
                    win_idx    = owner_r;
                    keep_owner = 1'b1;
                end else if (pick_vld) begin
                    win_vld = 1'b1;
                end
            end else if (q[owner_r]) begin
                win_vld    = 1'b1;
                win_idx    = owner_r;
                keep_owner = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            ptr      <= IW'(NPORT - 1);
            owner_r  <= '0;
            hold_cnt <= '0;
            sel_r    <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner_r  <= owner_n;
            hold_cnt <= hold_n;
            sel_r    <= grt;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner_r;
        hold_n  = hold_cnt;
        if (out_ready) begin
            if (state == IDLE) begin
                if (win_vld) begin
                    ptr_n   = win_idx;
                    owner_n = win_idx;
                    hold_n  = HW'(1);
                    if ((LOCKMODE == 0) || !tail[win_idx]) begin
                        state_n = LOCKED;
                    end
                end
            end else if (LOCKMODE == 0) begin
                if (keep_owner) begin
                    if ((MAXHOLD != 0) && (int'(hold_cnt) < MAXHOLD)) begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end else if (win_vld) begin
                    ptr_n   = win_idx;
                    owner_n = win_idx;
                    hold_n  = HW'(1);
                end else begin
                    state_n = IDLE;
                end
            end else if (keep_owner && tail[owner_r]) begin
                state_n = IDLE;
                ptr_n   = owner_r;
            end
        end
    end

    always_comb begin
        grt = '0;
        if (win_vld) begin
            grt[win_idx] = 1'b1;
        end
        sel          = sel_r;
        owner        = owner_r;
        busy         = (state == LOCKED);
        dbg_state    = state;
        dbg_ptr      = ptr;
        dbg_hold_cnt = hold_cnt;
    end

endmodule

// File: tb/tb_xbar_out_alloc.sv
// Bench for xbar_out_alloc: three instances (hold, capped hold, packet lock) share stimulus;
// expected grants are queued at drive time and popped when the DUT output is sampled.
module tb_xbar_out_alloc;

    logic        clk = 1'b0;
    logic        rst_;
    logic [14:0] dest;
    logic [4:0]  req;
    logic [4:0]  tail;
    logic        out_ready;

    logic [4:0] grt_h, sel_h, grt_c, sel_c, grt_p, sel_p;
    logic [2:0] owner_h, owner_c, owner_p, ptr_h, ptr_c, ptr_p;
    logic       busy_h, busy_c, busy_p, st_h, st_c, st_p;
    logic [0:0] hc_h, hc_p;
    logic [1:0] hc_c;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_g;

    xbar_out_alloc #(.NPORT(5), .PORTW(3), .PORTID(2), .LOCKMODE(0), .MAXHOLD(0)) u_hold (
        .clk(clk), .rst_(rst_), .dest(dest), .req(req), .tail(tail), .out_ready(out_ready),
        .grt(grt_h), .sel(sel_h), .owner(owner_h), .busy(busy_h),
        .dbg_state(st_h), .dbg_ptr(ptr_h), .dbg_hold_cnt(hc_h));

    xbar_out_alloc #(.NPORT(5), .PORTW(3), .PORTID(2), .LOCKMODE(0), .MAXHOLD(3)) u_cap (
        .clk(clk), .rst_(rst_), .dest(dest), .req(req), .tail(tail), .out_ready(out_ready),
        .grt(grt_c), .sel(sel_c), .owner(owner_c), .busy(busy_c),
        .dbg_state(st_c), .dbg_ptr(ptr_c), .dbg_hold_cnt(hc_c));

    xbar_out_alloc #(.NPORT(5), .PORTW(3), .PORTID(2), .LOCKMODE(1), .MAXHOLD(0)) u_pkt (
        .clk(clk), .rst_(rst_), .dest(dest), .req(req), .tail(tail), .out_ready(out_ready),
        .grt(grt_p), .sel(sel_p), .owner(owner_p), .busy(busy_p),
        .dbg_state(st_p), .dbg_ptr(ptr_p), .dbg_hold_cnt(hc_p));

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required summary before 200000");
        $fatal(1, "watchdog");
    end

    // Drivers
    task automatic set_dest(input logic [2:0] d0, d1, d2, d3, d4);
        dest = {d4, d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_      = 1'b0;
        req       = '0;
        tail      = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic rdy,
                         input logic [4:0] exp_grt);
        @(negedge clk);
        req       = r;
        tail      = t;
        out_ready = rdy;
        exp_q.push_back(exp_grt);
    endtask

    // Scenarios
    task automatic test_reset();
        @(negedge clk);
        rst_      = 1'b0;
        req       = 5'b11111;
        tail      = '0;
        out_ready = 1'b1;
        set_dest(2, 2, 2, 2, 2);
        #1;
        n_cmp++;
        if ({grt_h, grt_c, grt_p} !== 15'b0) begin
            n_err++;
            $display("FAIL reset_grt: got %b/%b/%b required 0", grt_h, grt_c, grt_p);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({sel_h, sel_c, sel_p} !== 15'b0 || {busy_h, busy_c, busy_p} !== 3'b0) begin
            n_err++;
            $display("FAIL reset_sel_busy: got sel %b/%b/%b busy %b%b%b required 0",
                     sel_h, sel_c, sel_p, busy_h, busy_c, busy_p);
        end
        n_cmp++;
        if (ptr_h !== 3'd4 || ptr_c !== 3'd4 || ptr_p !== 3'd4) begin
            n_err++;
            $display("FAIL reset_ptr: got %0d/%0d/%0d required 4", ptr_h, ptr_c, ptr_p);
        end
        n_cmp++;
        if (owner_h !== 3'd0 || owner_p !== 3'd0 || hc_c !== 2'd0) begin
            n_err++;
            $display("FAIL reset_owner_hold: got owner %0d/%0d hold %0d required 0/0/0",
                     owner_h, owner_p, hc_c);
        end
        req = '0;
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic test_hold_unlimited();
        logic [4:0] rq [7] = '{5'b10000, 5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11011};
        logic [4:0] eg [7] = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
        logic       eb [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        set_dest(2, 2, 2, 2, 3);
        for (int c = 0; c < 7; c++) begin
            drive(rq[c], 5'b0, 1'b1, eg[c]);
            #1;
            exp_g = exp_q.pop_front();
            n_cmp++;
            if (grt_h !== exp_g) begin
                n_err++;
                $display("FAIL hold_grt c%0d: got %b required %b", c, grt_h, exp_g);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (sel_h !== exp_g || busy_h !== eb[c]) begin
                n_err++;
                $display("FAIL hold_sel_busy c%0d: got sel %b busy %b required sel %b busy %b",
                         c, sel_h, busy_h, exp_g, eb[c]);
            end
        end
        n_cmp++;
        if (owner_h !== 3'd0) begin
            n_err++;
            $display("FAIL hold_owner: got %0d required 0", owner_h);
        end
    endtask

    task automatic test_maxhold();
        logic [4:0] eg [12] = '{5'b00001, 5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b00010,
                                5'b01000, 5'b01000, 5'b01000, 5'b00001, 5'b00001, 5'b00001};
        int         eh [12] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 3};
        int         eo [12] = '{0, 0, 0, 1, 1, 1, 3, 3, 3, 0, 0, 0};
        do_reset();
        set_dest(2, 2, 2, 2, 3);
        for (int c = 0; c < 12; c++) begin
            drive(5'b11011, 5'b0, 1'b1, eg[c]);
            #1;
            exp_g = exp_q.pop_front();
            n_cmp++;
            if (grt_c !== exp_g) begin
                n_err++;
                $display("FAIL cap_grt c%0d: got %b required %b", c, grt_c, exp_g);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (hc_c !== 2'(eh[c]) || owner_c !== 3'(eo[c]) || sel_c !== exp_g) begin
                n_err++;
                $display("FAIL cap_state c%0d: got hold %0d owner %0d sel %b required %0d %0d %b",
                         c, hc_c, owner_c, sel_c, eh[c], eo[c], exp_g);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [4:0] rq [6] = '{5'b10000, 5'b10010, 5'b10010, 5'b10010, 5'b00010, 5'b00000};
        logic [4:0] tl [6] = '{5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b00010, 5'b00000};
        logic [4:0] eg [6] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00010, 5'b00000};
        logic       eb [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int         ep [6] = '{4, 4, 4, 4, 1, 1};
        do_reset();
        set_dest(2, 2, 2, 2, 2);
        for (int c = 0; c < 6; c++) begin
            drive(rq[c], tl[c], 1'b1, eg[c]);
            #1;
            exp_g = exp_q.pop_front();
            n_cmp++;
            if (grt_p !== exp_g) begin
                n_err++;
                $display("FAIL pkt_grt c%0d: got %b required %b", c, grt_p, exp_g);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (busy_p !== eb[c] || ptr_p !== 3'(ep[c]) || sel_p !== exp_g) begin
                n_err++;
                $display("FAIL pkt_state c%0d: got busy %b ptr %0d sel %b required %b %0d %b",
                         c, busy_p, ptr_p, sel_p, eb[c], ep[c], exp_g);
            end
        end
    endtask

    task automatic test_bubble();
        logic [4:0] rq [7] = '{5'b01000, 5'b01001, 5'b00001, 5'b00001, 5'b01001, 5'b00001, 5'b00000};
        logic [4:0] tl [7] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b00000};
        logic [4:0] eg [7] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b01000, 5'b00001, 5'b00000};
        logic       eb [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int         eo [7] = '{3, 3, 3, 3, 3, 0, 0};
        do_reset();
        set_dest(2, 2, 2, 2, 2);
        for (int c = 0; c < 7; c++) begin
            drive(rq[c], tl[c], 1'b1, eg[c]);
            #1;
            exp_g = exp_q.pop_front();
            n_cmp++;
            if (grt_p !== exp_g) begin
                n_err++;
                $display("FAIL bubble_grt c%0d: got %b required %b", c, grt_p, exp_g);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (busy_p !== eb[c] || owner_p !== 3'(eo[c])) begin
                n_err++;
                $display("FAIL bubble_state c%0d: got busy %b owner %0d required %b %0d",
                         c, busy_p, owner_p, eb[c], eo[c]);
            end
        end
    endtask

    task automatic test_stall();
        logic       rd [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [4:0] eg [7] = '{5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00010};
        int         eh [7] = '{1, 2, 2, 2, 2, 3, 1};
        int         ep [7] = '{0, 0, 0, 0, 0, 0, 1};
        do_reset();
        set_dest(2, 2, 2, 2, 3);
        for (int c = 0; c < 7; c++) begin
            drive(5'b01011, 5'b0, rd[c], eg[c]);
            #1;
            exp_g = exp_q.pop_front();
            n_cmp++;
            if (grt_c !== exp_g) begin
                n_err++;
                $display("FAIL stall_grt c%0d: got %b required %b", c, grt_c, exp_g);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (hc_c !== 2'(eh[c]) || ptr_c !== 3'(ep[c]) || busy_c !== 1'b1) begin
                n_err++;
                $display("FAIL stall_state c%0d: got hold %0d ptr %0d busy %b required %0d %0d 1",
                         c, hc_c, ptr_c, busy_c, eh[c], ep[c]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_dest(2, 2, 2, 2, 2);
        for (int c = 0; c < 2; c++) begin
            drive(5'b00100, 5'b0, 1'b1, 5'b00100);
            #1;
            exp_g = exp_q.pop_front();
            n_cmp++;
            if (grt_p !== exp_g) begin
                n_err++;
                $display("FAIL areset_pre_grt c%0d: got %b required %b", c, grt_p, exp_g);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (busy_p !== 1'b1 || sel_p !== 5'b00100) begin
            n_err++;
            $display("FAIL areset_locked: got busy %b sel %b required 1 00100", busy_p, sel_p);
        end
        @(negedge clk);
        #2;
        rst_ = 1'b0;
        req  = '0;
        #1;
        n_cmp++;
        if (busy_p !== 1'b0 || sel_p !== 5'b0 || grt_p !== 5'b0) begin
            n_err++;
            $display("FAIL areset_drop: got busy %b sel %b grt %b required 0", busy_p, sel_p, grt_p);
        end
        @(negedge clk);
        rst_ = 1'b1;
        drive(5'b00101, 5'b0, 1'b1, 5'b00001);
        #1;
        exp_g = exp_q.pop_front();
        n_cmp++;
        if (grt_p !== exp_g) begin
            n_err++;
            $display("FAIL areset_first_grt: got %b required %b", grt_p, exp_g);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy_p !== 1'b1 || owner_p !== 3'd0) begin
            n_err++;
            $display("FAIL areset_after: got busy %b owner %0d required 1 0", busy_p, owner_p);
        end
    endtask

    initial begin
        rst_      = 1'b0;
        dest      = '0;
        req       = '0;
        tail      = '0;
        out_ready = 1'b0;
        test_reset();
        test_hold_unlimited();
        test_maxhold();
        test_packet_lock();
        test_bubble();
        test_stall();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xbar_out_alloc.md
# xbar_out_alloc

Parametrised per-output-port allocator for the crossbar of the NxN router. One instance sits at each output port. It qualifies the N input requests whose destination field matches its own port ID and grants one of them with rotating priority. It holds the grant either while the winner keeps requesting (legacy hold mode, with an optional fairness cap) or until the winner's tail flit transfers (wormhole packet-lock mode). It also drives a registered one-hot select for the crossbar data mux.

## Interface
- NPORT, 5, number of input ports (2..16)
- PORTW, 3, width of each destination field
- PORTID, 0, this output port's ID; compared against each destination field
- LOCKMODE, 0, 0 = request-hold, 1 = packet-lock (release on tail)
- MAXHOLD, 0, mode 0 only: maximum consecutive grants to one owner while others wait; 0 = unlimited
- clk  input  1  clock, all state on rising edge
- rst_  input  1  asynchronous, active-low reset
- dest  input  NPORT*PORTW  destination fields; port i uses bits [i*PORTW +: PORTW]
- req  input  NPORT  request valid per input port
- tail  input  NPORT  flit on port i is the last of its packet (used in mode 1 only)
- out_ready  input  1  downstream can accept a flit this cycle
- grt  output  NPORT  one-hot or zero; combinational; grt[i]=1 means port i's flit transfers this cycle
- sel  output  NPORT  registered copy of grt; drives the crossbar data mux
- owner  output  clog2(NPORT)  index of the current lock holder; valid when busy=1
- busy  output  1  registered; a lock is held

## Operation
- Qualified request: q[i] = req[i] & (dest field of port i == PORTID).
- State is IDLE or LOCKED, plus owner, rotating pointer ptr, and hold_cnt (width clog2(MAXHOLD+1), minimum 1).
- RR pick: the first i with q[i]=1, searching ptr+1, ptr+2, … modulo NPORT.
- out_ready=0: grt=0. State, ptr and hold_cnt are unchanged.
- IDLE with out_ready=1: grt = onehot(RR pick), or 0 if no q. On a grant to port w:
  - ptr <= w, owner <= w, hold_cnt <= 1.
  - Mode 0: go to LOCKED.
  - Mode 1: go to LOCKED only if tail[w]=0. A single-flit packet (tail=1) stays IDLE.
- LOCKED, mode 0, out_ready=1:
  - If q[owner]=1, and either MAXHOLD=0, hold_cnt<MAXHOLD, or no other q is set: grant owner and increment hold_cnt, saturating at MAXHOLD.
  - Otherwise, if any other q is set: grant the RR pick with the search starting at owner+1. The new winner becomes owner, ptr <= winner, hold_cnt <= 1. This handover happens in the same cycle.
  - Otherwise grt=0 and the block returns to IDLE.
- LOCKED, mode 1, out_ready=1:
  - Grant owner if q[owner]=1. Otherwise grt=0 and the lock is kept (bubble); other ports are never granted.
  - A granted flit with tail[owner]=1 moves the block to IDLE and sets ptr <= owner.
  - Re-arbitration happens no earlier than the next cycle.
- hold_cnt is ignored in mode 1.
- grt is always zero or one-hot and never grants a port with q=0.

## Timing
- grt is combinational from req, dest, tail, out_ready and state: zero-cycle grant.
- sel <= grt on every rising edge, so it is valid exactly one cycle after the grant, aligned with the registered flit in the crossbar.
- busy and owner reflect the state after the edge.
- Reset (asynchronous assert, synchronous release):
  - state IDLE, ptr = NPORT-1 (port 0 has first priority), owner 0, hold_cnt 0.
  - sel 0, busy 0; grt is 0 while in reset.
- Reset mid-packet drops the lock immediately. There is no recovery of a partial packet.
- A tail transfer on one port while another port raises its request in the same cycle: the new port is granted at the earliest in the next cycle.
- Throughput: one flit per cycle while out_ready=1 and the owner keeps requesting.

## Test plan
- Reset, then NPORT=5, PORTID=2; ports 0, 1 and 3 request dest=2 continuously in mode 0, MAXHOLD=0 → port 0 is granted every cycle; sel=5'b00001 from cycle+1; busy=1.
- Same stimulus with MAXHOLD=3 → grants follow 0,0,0,1,1,1,3,3,3,0…; hold_cnt wraps to 1 on every handover.
- Mode 1: port 4 sends a 4-flit packet (tail on the 4th flit) and port 1 requests from the 2nd cycle → grt=port 4 for 4 cycles, then port 1 in the next cycle; ptr=4.
- Mode 1: the owner drops req for 2 cycles mid-packet while port 0 requests → grt=0 for those 2 cycles; port 0 is not granted until the owner's tail transfers.
- out_ready low for 3 cycles during a lock → grt=0, hold_cnt and ptr frozen; the transfer resumes with the same owner.
- Assert rst_=0 asynchronously mid-packet → busy and sel go to 0 without a clock edge; after release, a port 0 request is granted first.
